hmac_drbg_ctrl: RTL and testbench
=================================

HMAC_DRBG_CTRL -- requirements
Module: hmac_drbg_ctrl

Interface
REQ-001 SHALL provide parameter RETRY_LIMIT, default 8, meaning max SIGN reseed retries (1..15).
REQ-002 SHALL provide ports, one per line:
  clk  input  1  rising-edge clock for all state
  reset_n  input  1  synchronous active-low reset
  init  input  1  start pulse; sampled only when ready=1
  keygen_sign  input  1  mode sampled with init: 0=KEYGEN, 1=SIGN
  ready  output  1  controller idle, accepts init
  drbg_load  output  1  one-cycle pulse: datapath loads K=all-zero, V=all-0x01 (384 b)
  seed_sel  output  1  registered mode: 0=seed material, 1=privKey||hash
  hmac_start  output  1  one-cycle pulse to HMAC-384 core
  hmac_op  output  3  operation for the datapath
  hmac_done  input  1  one-cycle pulse: core finished, tag written per hmac_op
  range_ok  input  1  datapath compare 0 < T < n, valid in CHCK
  nonce_valid  output  1  nonce register holds a final result
  error  output  1  retry limit exceeded (REQ-019)

Function
REQ-003 hmac_op encoding SHALL be: 1=K_UPD0 K=HMAC(K,V||0x00||mat), 2=V_UPD V=HMAC(K,V), 3=K_UPD1 K=HMAC(K,V||0x01||mat), 4=T_GEN V=HMAC(K,V) and nonce=V, 5=K_RESEED K=HMAC(K,V||0x00); 0 in IDLE/LOAD/CHCK/DONE.
REQ-004 States SHALL be IDLE, LOAD, K1, V1, K2, V2, T, CHCK, K3, V3, DONE.
REQ-005 ready SHALL be 1 only in IDLE and DONE.
REQ-006 In IDLE/DONE, init=1 SHALL latch keygen_sign into seed_sel, clear nonce_valid and error, enter LOAD next cycle.
REQ-007 LOAD SHALL assert drbg_load for exactly one cycle, then enter K1.
REQ-008 Each of K1,V1,K2,V2,T,K3,V3 SHALL: first cycle assert hmac_start=1 for one cycle; then wait with hmac_start=0 until hmac_done=1; then advance next cycle.
REQ-009 hmac_op SHALL be registered, valid in the hmac_start cycle, held stable until the cycle after hmac_done.
REQ-010 Op per state: K1=1, V1=2, K2=3, V2=2, T=4, K3=5, V3=2.
REQ-011 Sequence: K1->V1->K2->V2->T.
REQ-012 KEYGEN: T done -> DONE with nonce_valid=1.
REQ-013 SIGN: T done -> CHCK; CHCK lasts one cycle, samples range_ok.
REQ-014 CHCK range_ok=1 -> DONE, nonce_valid=1; range_ok=0 -> K3 -> V3 -> T.
REQ-015 hmac_done outside a wait phase, and in the hmac_start cycle itself, SHALL be ignored.
REQ-016 init while not ready SHALL be ignored; seed_sel SHALL not change mid-run.
REQ-017 nonce_valid and error SHALL hold in DONE until the next accepted init.

Reset
REQ-018 reset_n=0 at a clock edge SHALL force IDLE and set ready=1, drbg_load=0, hmac_start=0, hmac_op=0, seed_sel=0, nonce_valid=0, error=0, retry count=0, from any state including mid-wait; a pending hmac_done after reset SHALL be ignored.

Configuration
REQ-019 With macro HMAC_DRBG_RETRY_LIMIT_EN defined: a 4-bit retry counter SHALL clear on accepted init and increment on each CHCK fail; a fail when the count already equals RETRY_LIMIT SHALL go to DONE with error=1, nonce_valid=0, no K3 issued.
REQ-020 Without HMAC_DRBG_RETRY_LIMIT_EN: no counter; retries unbounded; error SHALL be tied 0.

Verification
REQ-021 KEYGEN, hmac_done 3 cycles after each start -> hmac_op sequence 1,2,3,2,4; exactly 5 start pulses; nonce_valid=1; error=0.
REQ-022 SIGN, range_ok=1 -> ops 1,2,3,2,4; one CHCK cycle; DONE, seed_sel=1, nonce_valid=1.
REQ-023 SIGN, range_ok=0 twice then 1 -> ops 1,2,3,2,4,5,2,4,5,2,4; 11 starts; nonce_valid=1.
REQ-024 Macro on, RETRY_LIMIT=2, range_ok always 0 -> ops 1,2,3,2,4,5,2,4,5,2,4; then DONE, error=1, nonce_valid=0.
REQ-025 reset_n=0 while waiting in K2, then init, spurious hmac_done -> IDLE, all outputs per REQ-018; spurious done ignored; new run starts at LOAD.
REQ-026 init during V1 wait and hmac_done in a start cycle -> both ignored; sequence and seed_sel unchanged.

Source files
------------

// File: rtl/hmac_drbg_ctrl.sv
// hmac_drbg_ctrl -- sequencing controller for an HMAC-384 DRBG (RFC 6979 style nonce generation).
//
// Drives a K/V datapath through the instantiate/generate steps:
//   LOAD -> K1 -> V1 -> K2 -> V2 -> T [-> CHCK -> (K3 -> V3 -> T)*] -> DONE
// KEYGEN runs finish after the first T. SIGN runs range-check T (0 < T < n) and reseed on failure.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      synchronous active-low reset
//   init         start pulse, honoured only while ready=1
//   keygen_sign  mode captured with init (0 = KEYGEN, 1 = SIGN)
//   ready        idle / done, accepts init
//   drbg_load    one-cycle pulse: datapath loads K = 0x00.., V = 0x01..
//   seed_sel     captured mode: 0 = seed material, 1 = privKey||hash
//   hmac_start   one-cycle start pulse to the HMAC core
//   hmac_op      datapath operation, valid from start until the done cycle
//   hmac_done    one-cycle completion pulse from the HMAC core
//   range_ok     datapath range compare, sampled in CHCK
//   nonce_valid  nonce register holds a final result
//   error        SIGN retry limit exceeded
//
// Configuration:
//   HMAC_DRBG_RETRY_LIMIT_EN  when defined, SIGN reseeds are bounded by RETRY_LIMIT and an
//                             overrun ends the run with error=1. Otherwise retries are unbounded
//                             and error is tied low.

module hmac_drbg_ctrl #(
  parameter int unsigned RETRY_LIMIT = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       init,
  input  logic       keygen_sign,
  output logic       ready,
  output logic       drbg_load,
  output logic       seed_sel,
  output logic       hmac_start,
  output logic [2:0] hmac_op,
  input  logic       hmac_done,
  input  logic       range_ok,
  output logic       nonce_valid,
  output logic       error
);

  if (RETRY_LIMIT < 1 || RETRY_LIMIT > 15) begin : g_bad_retry_limit
    $error("hmac_drbg_ctrl: RETRY_LIMIT must be in 1..15");
  end

  typedef enum logic [3:0] {
    StIdle, StLoad, StK1, StV1, StK2, StV2, StT, StChck, StK3, StV3, StDone
  } state_e;

  localparam logic [2:0] OpNone    = 3'd0;
  localparam logic [2:0] OpKUpd0   = 3'd1;
  localparam logic [2:0] OpVUpd    = 3'd2;
  localparam logic [2:0] OpKUpd1   = 3'd3;
  localparam logic [2:0] OpTGen    = 3'd4;
  localparam logic [2:0] OpKReseed = 3'd5;

  state_e state_q;

  // hmac_start is high only in the first cycle of an HMAC state, so a done seen while it is
  // high belongs to that start cycle and is discarded.
  logic op_done;
  assign op_done = hmac_done & ~hmac_start;

`ifdef HMAC_DRBG_RETRY_LIMIT_EN
  localparam logic [3:0] RetryLimit = 4'(RETRY_LIMIT);
  logic [3:0] retry_q;
  logic       error_q;
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      ready       <= 1'b1;
      drbg_load   <= 1'b0;
      hmac_start  <= 1'b0;
      hmac_op     <= OpNone;
      seed_sel    <= 1'b0;
      nonce_valid <= 1'b0;
`ifdef HMAC_DRBG_RETRY_LIMIT_EN
      retry_q     <= 4'd0;
      error_q     <= 1'b0;
`endif
    end else begin
      // Pulses default low; each transition below re-asserts what it needs.
      drbg_load  <= 1'b0;
      hmac_start <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (init) begin
            state_q     <= StLoad;
            ready       <= 1'b0;
            drbg_load   <= 1'b1;
            seed_sel    <= keygen_sign;
            nonce_valid <= 1'b0;
`ifdef HMAC_DRBG_RETRY_LIMIT_EN
            retry_q     <= 4'd0;
            error_q     <= 1'b0;
`endif
          end
        end
        StLoad: begin
          state_q    <= StK1;
          hmac_start <= 1'b1;
          hmac_op    <= OpKUpd0;
        end
        StK1: begin
          if (op_done) begin
            state_q    <= StV1;
            hmac_start <= 1'b1;
            hmac_op    <= OpVUpd;
          end
        end
        StV1: begin
          if (op_done) begin
            state_q    <= StK2;
            hmac_start <= 1'b1;
            hmac_op    <= OpKUpd1;
          end
        end
        StK2: begin
          if (op_done) begin
            state_q    <= StV2;
            hmac_start <= 1'b1;
            hmac_op    <= OpVUpd;
          end
        end
        StV2: begin
          if (op_done) begin
            state_q    <= StT;
            hmac_start <= 1'b1;
            hmac_op    <= OpTGen;
          end
        end
        StT: begin
          if (op_done) begin
            hmac_op <= OpNone;
            if (seed_sel) begin
              state_q <= StChck;
            end else begin
              state_q     <= StDone;
              ready       <= 1'b1;
              nonce_valid <= 1'b1;
            end
          end
        end
        StChck: begin
          if (range_ok) begin
            state_q     <= StDone;
            ready       <= 1'b1;
            nonce_valid <= 1'b1;
          end else begin
`ifdef HMAC_DRBG_RETRY_LIMIT_EN
            if (retry_q == RetryLimit) begin
              state_q <= StDone;
              ready   <= 1'b1;
              error_q <= 1'b1;
            end else begin
              retry_q    <= retry_q + 4'd1;
              state_q    <= StK3;
              hmac_start <= 1'b1;
              hmac_op    <= OpKReseed;
            end
`else
            state_q    <= StK3;
            hmac_start <= 1'b1;
            hmac_op    <= OpKReseed;
`endif
          end
        end
        StK3: begin
          if (op_done) begin
            state_q    <= StV3;
            hmac_start <= 1'b1;
            hmac_op    <= OpVUpd;
          end
        end
        StV3: begin
          if (op_done) begin
            state_q    <= StT;
            hmac_start <= 1'b1;
            hmac_op    <= OpTGen;
          end
        end
        default: begin
          state_q <= StIdle;
          ready   <= 1'b1;
          hmac_op <= OpNone;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hmac_drbg_ctrl.sv
// tb_hmac_drbg_ctrl -- self-checking bench for hmac_drbg_ctrl.
// A reference model builds the expected HMAC operation list for each run from the mode and the
// number of range-check failures; a responder answers each start with a random-latency done.

module tb_hmac_drbg_ctrl;

  localparam int Limit = 2;
`ifdef HMAC_DRBG_RETRY_LIMIT_EN
  localparam bit LimitEn = 1'b1;
`else
  localparam bit LimitEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       init;
  logic       keygen_sign;
  logic       ready;
  logic       drbg_load;
  logic       seed_sel;
  logic       hmac_start;
  logic [2:0] hmac_op;
  logic       hmac_done;
  logic       range_ok;
  logic       nonce_valid;
  logic       error;

  int errors = 0;
  int checks = 0;

  hmac_drbg_ctrl #(.RETRY_LIMIT(Limit)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .init        (init),
    .keygen_sign (keygen_sign),
    .ready       (ready),
    .drbg_load   (drbg_load),
    .seed_sel    (seed_sel),
    .hmac_start  (hmac_start),
    .hmac_op     (hmac_op),
    .hmac_done   (hmac_done),
    .range_ok    (range_ok),
    .nonce_valid (nonce_valid),
    .error       (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_load"}, drbg_load, 0);
    check({tag, "_start"}, hmac_start, 0);
    check({tag, "_op"}, hmac_op, 0);
    check({tag, "_seed_sel"}, seed_sel, 0);
    check({tag, "_nonce_valid"}, nonce_valid, 0);
    check({tag, "_error"}, error, 0);
  endtask

  // One full run: init, respond to every start, compare against the model's expectations.
  // nfails = number of leading range checks that fail. noise injects ignored init pulses and
  // done pulses in start cycles. fixed_lat > 0 forces that done latency.
  task automatic run_and_check(input bit sign, input int nfails, input bit noise,
                               input int fixed_lat);
    int  exp_ops[$];
    bit  exp_err;
    int  starts;
    int  loads;
    int  t_seen;
    int  cnt;
    int  cur_op;
    bit  finished;
    exp_ops = '{1, 2, 3, 2, 4};
    exp_err = 1'b0;
    if (sign) begin
      for (int f = 0; f < nfails; f++) begin
        if (LimitEn && f == Limit) begin
          exp_err = 1'b1;
          break;
        end
        exp_ops.push_back(5);
        exp_ops.push_back(2);
        exp_ops.push_back(4);
      end
    end

    starts = 0; loads = 0; t_seen = 0; cnt = 0; cur_op = 0; finished = 1'b0;
    @(negedge clk);
    init        = 1'b1;
    keygen_sign = sign;
    range_ok    = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      init      = 1'b0;
      hmac_done = 1'b0;
      if (n == 0) check("ready_drops", ready, 0);
      if (n > 0 && ready) begin
        finished = 1'b1;
        break;
      end
      if (drbg_load) loads++;
      if (hmac_start) begin
        starts++;
        if (starts <= exp_ops.size()) check("op_seq", hmac_op, exp_ops[starts-1]);
        else check("extra_start_op", hmac_op, 32'hff);
        cur_op = hmac_op;
        if (cur_op == 4) t_seen++;
        cnt = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
        if (noise && $urandom_range(0, 1) == 1) hmac_done = 1'b1;
      end else if (cnt > 0) begin
        check("op_hold", hmac_op, cur_op);
        cnt--;
        if (cnt == 0) hmac_done = 1'b1;
        else if (noise && $urandom_range(0, 3) == 0) begin
          init        = 1'b1;
          keygen_sign = 1'($urandom);
        end
      end
      range_ok = (t_seen > nfails);
    end
    check("run_finished", finished, 1);
    check("start_count", starts, exp_ops.size());
    check("load_count", loads, 1);
    check("seed_sel", seed_sel, sign);
    check("nonce_valid", nonce_valid, !exp_err);
    check("error", error, exp_err);
    check("done_op", hmac_op, 0);
    @(negedge clk);
    check("nonce_valid_hold", nonce_valid, !exp_err);
    check("error_hold", error, exp_err);
    check("ready_hold", ready, 1);
  endtask

  initial begin
    bit found;
    reset_n     = 1'b0;
    init        = 1'b0;
    keygen_sign = 1'b0;
    hmac_done   = 1'b0;
    range_ok    = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;

    // Stray done while idle must not start anything.
    hmac_done = 1'b1;
    @(negedge clk);
    hmac_done = 1'b0;
    check("idle_done_ready", ready, 1);
    check("idle_done_start", hmac_start, 0);

    run_and_check(1'b0, 0, 1'b0, 3);              // KEYGEN
    run_and_check(1'b1, 0, 1'b0, 3);              // SIGN, first T in range
    run_and_check(1'b1, 2, 1'b0, 2);              // SIGN, two reseeds
    run_and_check(1'b1, Limit + 1, 1'b0, 1);      // SIGN, fails past the limit
    run_and_check(1'b1, 1, 1'b1, 0);              // noisy inputs
    for (int i = 0; i < 6; i++) begin
      run_and_check(1'($urandom), int'($urandom_range(0, 3)), 1'b1, 0);
    end

    // Reset while waiting in K2, with init and keygen_sign high during reset.
    @(negedge clk);
    init        = 1'b1;
    keygen_sign = 1'b1;
    @(negedge clk);
    init  = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (hmac_start && hmac_op == 3) begin
        found = 1'b1;
        break;
      end
      if (hmac_start) begin
        @(negedge clk);
        hmac_done = 1'b1;
      end
      @(negedge clk);
      hmac_done = 1'b0;
    end
    check("k2_reached", found, 1);
    @(negedge clk);
    reset_n = 1'b0;
    init    = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    init    = 1'b0;
    check_idle_outputs("mid_reset");
    hmac_done = 1'b1;
    @(negedge clk);
    hmac_done = 1'b0;
    check("post_reset_ready", ready, 1);
    check("post_reset_start", hmac_start, 0);
    check("post_reset_op", hmac_op, 0);
    run_and_check(1'b0, 0, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
